// File: rtl/core_host_seq.sv
// core_host_seq: autonomous host sequencer streaming source SRAM words and instruction bits into core_ctrl (optional watchdog: CORE_HOST_TIMEOUT_EN)
module core_host_seq #(
  parameter int bw = 4,
  parameter int row = 8,
  parameter int col = 8,
  parameter int len_nij = 16,
  parameter int M_sqr = 36,
  parameter int K = 3,
  parameter int GAP = 5,
  parameter int src_aw = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  output logic              src_cen,
  output logic [src_aw-1:0] src_addr,
  input  logic [31:0]       src_q,
  output logic [3:0]        inst,
  output logic [3:0]        kij,
  output logic              wen_act_wgt,
  output logic              cen_act_wgt,
  output logic [31:0]       din_act_wgt,
  input  logic              core_done,
  output logic              busy,
  output logic              run_done
`ifdef CORE_HOST_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);
  typedef enum logic [3:0] {IDLE, CLR, GAP1, ACT, GAP2, WGT, GAPW, START, STOP, FIN, DONE} state_t;
  state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [3:0] k, k_n;
  logic rd, wr, win;
`ifdef CORE_HOST_TIMEOUT_EN
  logic tmo_n;
`endif
  if (bw * row != 32 || bw * col != 32 || M_sqr + K * K * col > (1 << src_aw)) begin : g_cfg
    $error("core_host_seq: parameters do not fit a 32b word or the source address space");
  end
  // Write data is the source SRAM output itself, exposed only while a core write is in progress
  assign din_act_wgt = wen_act_wgt ? '0 : src_q;
  // Next-state, phase counter and kernel index; outputs are decoded from the next state so they register in step with it
  always_comb begin
    state_n = state;
    cnt_n = cnt + 16'd1;
    k_n = k;
`ifdef CORE_HOST_TIMEOUT_EN
    tmo_n = timeout_err;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (go) begin
          state_n = CLR;
          k_n = '0;
`ifdef CORE_HOST_TIMEOUT_EN
          tmo_n = 1'b0;
`endif
        end
      end
      CLR:  if (cnt == 16'(len_nij + 1)) begin state_n = GAP1; cnt_n = '0; end
      GAP1: if (cnt == 16'(GAP - 1)) begin state_n = ACT; cnt_n = '0; end
      ACT:  if (cnt == 16'(M_sqr)) begin state_n = GAP2; cnt_n = '0; end
      GAP2: if (cnt == 16'(GAP - 1)) begin state_n = WGT; cnt_n = '0; end
      WGT:  if (cnt == 16'(col)) begin state_n = GAPW; cnt_n = '0; end
      GAPW: if (cnt == 16'(GAP - 1)) begin state_n = START; cnt_n = '0; end
      START: begin
        if (core_done) begin
          state_n = STOP;
          cnt_n = '0;
        end
`ifdef CORE_HOST_TIMEOUT_EN
        else if (cnt == 16'hFFFE) begin
          state_n = DONE;
          cnt_n = '0;
          tmo_n = 1'b1;
        end
`endif
      end
      STOP: begin
        cnt_n = '0;
        state_n = k < 4'(K * K - 1) ? WGT : FIN;
        k_n = k < 4'(K * K - 1) ? k + 4'd1 : k;
      end
      FIN:  if (cnt == 16'(len_nij - 1)) begin state_n = DONE; cnt_n = '0; end
      DONE: begin state_n = IDLE; cnt_n = '0; end
      default: begin state_n = IDLE; cnt_n = '0; end
    endcase
    rd = (state_n == ACT && cnt_n < 16'(M_sqr)) || (state_n == WGT && cnt_n < 16'(col));
    wr = (state_n == ACT || state_n == WGT) && cnt_n != '0;
    win = state_n inside {WGT, GAPW, START, STOP};
  end
  // State and registered outputs; the core write trails its source read by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      k <= '0;
      src_cen <= 1'b1;
      src_addr <= '0;
      inst <= '0;
      kij <= '0;
      wen_act_wgt <= 1'b1;
      cen_act_wgt <= 1'b1;
      busy <= 1'b0;
      run_done <= 1'b0;
`ifdef CORE_HOST_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      k <= k_n;
      src_cen <= !rd;
      src_addr <= !rd ? '0 : state_n == ACT ? src_aw'(cnt_n) : src_aw'(M_sqr + col * int'(k_n) + int'(cnt_n));
      inst <= {state_n == FIN, win & k_n[0], state_n == CLR, state_n == START};
      kij <= win ? k_n : '0;
      wen_act_wgt <= !wr;
      cen_act_wgt <= !wr;
      busy <= !(state_n inside {IDLE, DONE});
      run_done <= state_n == DONE;
`ifdef CORE_HOST_TIMEOUT_EN
      timeout_err <= tmo_n;
`endif
    end
  end
endmodule

// File: tb/tb_core_host_seq.sv
// tb_core_host_seq: scoreboard bench for core_host_seq with source SRAM and core_ctrl done models
module tb_core_host_seq;
  logic clk = 0, reset = 1, go = 0, core_done = 0;
  logic src_cen, wen_act_wgt, cen_act_wgt, busy, run_done;
  logic [10:0] src_addr;
  logic [31:0] src_q = 0, din_act_wgt;
  logic [3:0] inst, kij;
`ifdef CORE_HOST_TIMEOUT_EN
  logic timeout_err;
`endif
  int n_pass = 0, n_total = 0;
  int clr_n, fin_n, wr_n, rd_n, run_len, start_len, dcnt = 0, mode = 0;
  logic prev_cen = 1, prev_start = 0;
  logic [10:0] prev_addr = 0;
  logic [31:0] exp_q[$];
  int runs[$], starts[$];
  logic [3:0] kijs[$];
  logic rchips[$];

  core_host_seq dut (
    .clk(clk), .reset(reset), .go(go), .src_cen(src_cen), .src_addr(src_addr), .src_q(src_q),
    .inst(inst), .kij(kij), .wen_act_wgt(wen_act_wgt), .cen_act_wgt(cen_act_wgt),
    .din_act_wgt(din_act_wgt), .core_done(core_done), .busy(busy), .run_done(run_done)
`ifdef CORE_HOST_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  // Source SRAM holding word i = i, registered read
  always @(posedge clk) if (!src_cen) src_q <= {21'b0, src_addr};

  // core_ctrl model: mode 0 done 20 cycles into start, mode 1 always high, mode 2 never
  always @(posedge clk) begin
    if (!inst[0]) begin
      dcnt <= 0;
      core_done <= (mode == 1);
    end else begin
      dcnt <= dcnt + 1;
      core_done <= (mode == 1) || (mode == 0 && dcnt >= 19);
    end
  end

  // Monitor: pops the scoreboard on each core write and records phase statistics
  always @(negedge clk) begin
    if (reset) begin
      prev_cen = 1;
      prev_start = 0;
      run_len = 0;
      start_len = 0;
    end else begin
      if (inst[1]) clr_n++;
      if (inst[3]) fin_n++;
      if (run_done) rd_n++;
      if (!wen_act_wgt || !cen_act_wgt) begin
        run_len++;
        wr_n++;
        n_total++;
        if (exp_q.size() == 0) $display("FAIL sb_din got %0d want none (underflow)", din_act_wgt);
        else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (din_act_wgt !== e || wen_act_wgt !== cen_act_wgt) $display("FAIL sb_din got %0d want %0d", din_act_wgt, e);
          else n_pass++;
        end
        n_total++;
        if (prev_cen !== 1'b0 || din_act_wgt !== {21'b0, prev_addr}) $display("FAIL skew got din %0d want %0d (prev cen %b)", din_act_wgt, prev_addr, prev_cen);
        else n_pass++;
      end else if (run_len != 0) begin
        runs.push_back(run_len);
        run_len = 0;
      end
      if (inst[0]) begin
        if (!prev_start) begin
          kijs.push_back(kij);
          rchips.push_back(inst[2]);
        end
        start_len++;
      end else if (prev_start) begin
        starts.push_back(start_len);
        start_len = 0;
      end
      prev_start = inst[0];
      prev_cen = src_cen;
      prev_addr = src_addr;
    end
  end

  task automatic clear_stats();
    clr_n = 0; fin_n = 0; wr_n = 0; rd_n = 0;
    runs.delete(); starts.delete(); kijs.delete(); rchips.delete();
  endtask

  task automatic start_run();
    clear_stats();
    for (int i = 0; i < 108; i++) exp_q.push_back(i);
    @(negedge clk) go = 1;
    @(negedge clk) go = 0;
  endtask

  task automatic wait_done(input int lim, input bit inj, output bit ok);
    bit p1 = 0, p2 = 0;
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      go = 0;
      if (run_done) begin ok = 1; break; end
      if (inj && !p1 && wr_n == 10) begin go = 1; p1 = 1; end
      if (inj && !p2 && inst[0] && kij == 2) begin go = 1; p2 = 1; end
    end
    go = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++;
    if ({src_cen, wen_act_wgt, cen_act_wgt, inst, kij, busy, run_done, src_addr, din_act_wgt} !== {3'b111, 4'd0, 4'd0, 2'b00, 11'd0, 32'd0})
      $display("FAIL reset_vals got cen%b wen%b cen%b inst%h kij%h busy%b rd%b want 1 1 1 0 0 0 0", src_cen, wen_act_wgt, cen_act_wgt, inst, kij, busy, run_done);
    else n_pass++;
    @(negedge clk) reset = 0;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || src_cen !== 1'b1) $display("FAIL idle_after_reset got busy %b cen %b want 0 1", busy, src_cen);
    else n_pass++;
  endtask

  task automatic test_full_run();
    bit ok;
    mode = 0;
    start_run();
    n_total++;
    if (busy !== 1'b1) $display("FAIL busy_on_go got %b want 1", busy); else n_pass++;
    wait_done(5000, 0, ok);
    n_total++; if (!ok) $display("FAIL full_run_timeout got no run_done want run_done"); else n_pass++;
    n_total++; if (clr_n !== 18) $display("FAIL clr_cycles got %0d want 18", clr_n); else n_pass++;
    n_total++; if (wr_n !== 108) $display("FAIL writes got %0d want 108", wr_n); else n_pass++;
    n_total++; if (runs.size() !== 10) $display("FAIL write_groups got %0d want 10", runs.size()); else n_pass++;
    for (int i = 0; i < runs.size() && i < 10; i++) begin
      n_total++;
      if (runs[i] !== (i == 0 ? 36 : 8)) $display("FAIL group_len[%0d] got %0d want %0d", i, runs[i], i == 0 ? 36 : 8);
      else n_pass++;
    end
    n_total++; if (kijs.size() !== 9) $display("FAIL starts got %0d want 9", kijs.size()); else n_pass++;
    for (int i = 0; i < kijs.size() && i < 9; i++) begin
      n_total++;
      if (kijs[i] !== 4'(i) || rchips[i] !== 1'(i % 2)) $display("FAIL kij_rchip[%0d] got %0d/%b want %0d/%b", i, kijs[i], rchips[i], i, i % 2);
      else n_pass++;
    end
    n_total++; if (fin_n !== 16) $display("FAIL fin_cycles got %0d want 16", fin_n); else n_pass++;
    n_total++; if (rd_n !== 1) $display("FAIL run_done_count got %0d want 1", rd_n); else n_pass++;
    n_total++; if (busy !== 1'b0 || inst !== 4'd0 || kij !== 4'd0) $display("FAIL post_run got busy%b inst%h kij%h want 0 0 0", busy, inst, kij); else n_pass++;
    n_total++; if (exp_q.size() !== 0) $display("FAIL sb_leftover got %0d want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_done_high();
    bit ok;
    int bad = 0;
    mode = 1;
    start_run();
    wait_done(5000, 0, ok);
    n_total++; if (!ok) $display("FAIL done_high_timeout got no run_done want run_done"); else n_pass++;
    n_total++; if (starts.size() !== 9) $display("FAIL done_high_starts got %0d want 9", starts.size()); else n_pass++;
    foreach (starts[i]) if (starts[i] != 1) bad++;
    n_total++; if (bad !== 0) $display("FAIL done_high_start_len got %0d long starts want 0", bad); else n_pass++;
    n_total++; if (wr_n !== 108 || rd_n !== 1) $display("FAIL done_high_counts got %0d/%0d want 108/1", wr_n, rd_n); else n_pass++;
  endtask

  task automatic test_go_ignored();
    bit ok;
    mode = 0;
    start_run();
    wait_done(5000, 1, ok);
    n_total++; if (!ok) $display("FAIL go_ign_timeout got no run_done want run_done"); else n_pass++;
    n_total++; if (clr_n !== 18 || fin_n !== 16) $display("FAIL go_ign_clr_fin got %0d/%0d want 18/16", clr_n, fin_n); else n_pass++;
    n_total++; if (wr_n !== 108 || runs.size() !== 10) $display("FAIL go_ign_writes got %0d/%0d want 108/10", wr_n, runs.size()); else n_pass++;
    n_total++; if (kijs.size() !== 9 || rd_n !== 1) $display("FAIL go_ign_starts got %0d/%0d want 9/1", kijs.size(), rd_n); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok = 0;
    mode = 0;
    start_run();
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      ok = inst[0] && kij == 4;
    end
    n_total++; if (!ok) $display("FAIL mid_reach_kij4 got no kij4 start want kij4 start"); else n_pass++;
    #2 reset = 1;
    #1;
    n_total++;
    if ({src_cen, wen_act_wgt, cen_act_wgt, inst, kij, busy, run_done, src_addr, din_act_wgt} !== {3'b111, 4'd0, 4'd0, 2'b00, 11'd0, 32'd0})
      $display("FAIL async_reset got cen%b wen%b cen%b inst%h kij%h busy%b want 1 1 1 0 0 0", src_cen, wen_act_wgt, cen_act_wgt, inst, kij, busy);
    else n_pass++;
    repeat (2) @(negedge clk);
    exp_q.delete();
    reset = 0;
    @(negedge clk);
    start_run();
    wait_done(5000, 0, ok);
    n_total++; if (!ok) $display("FAIL rerun_timeout got no run_done want run_done"); else n_pass++;
    n_total++; if (clr_n !== 18 || fin_n !== 16) $display("FAIL rerun_clr_fin got %0d/%0d want 18/16", clr_n, fin_n); else n_pass++;
    n_total++; if (wr_n !== 108 || kijs.size() !== 9 || rd_n !== 1) $display("FAIL rerun_counts got %0d/%0d/%0d want 108/9/1", wr_n, kijs.size(), rd_n); else n_pass++;
  endtask

`ifdef CORE_HOST_TIMEOUT_EN
  task automatic test_timeout();
    bit ok = 0;
    mode = 2;
    clear_stats();
    @(negedge clk) go = 1;
    @(negedge clk) go = 0;
    for (int i = 0; i < 70000 && !ok; i++) begin
      @(negedge clk);
      ok = run_done;
    end
    n_total++; if (!ok) $display("FAIL tmo_no_run_done got none want pulse"); else n_pass++;
    n_total++; if (timeout_err !== 1'b1 || inst[0] !== 1'b0) $display("FAIL tmo_flag got err%b start%b want 1 0", timeout_err, inst[0]); else n_pass++;
    @(negedge clk);
    n_total++; if (starts.size() !== 1 || starts[0] !== 65535) $display("FAIL tmo_start_len got %0d want 65535", starts.size() ? starts[0] : -1); else n_pass++;
    n_total++; if (wr_n !== 44 || rd_n !== 1) $display("FAIL tmo_counts got %0d/%0d want 44/1", wr_n, rd_n); else n_pass++;
    mode = 0;
    start_run();
    n_total++; if (timeout_err !== 1'b0) $display("FAIL tmo_clear got %b want 0", timeout_err); else n_pass++;
    wait_done(5000, 0, ok);
    n_total++; if (!ok || timeout_err !== 1'b0 || rd_n !== 1) $display("FAIL tmo_rerun got done%b err%b rd%0d want 1 0 1", ok, timeout_err, rd_n); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_full_run();
    test_done_high();
    test_go_ignored();
    test_reset_mid();
`ifdef CORE_HOST_TIMEOUT_EN
    exp_q.delete();
    for (int i = 0; i < 44; i++) exp_q.push_back(i);
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
